// File: rtl/crp16_debug_clock.sv
// crp16_debug_clock: run-control for the CRP16 board top.
// Produces a one-cycle cpu_en strobe on CLOCK_50 in halt, free-run,
// debounced single-step and burst-of-N modes, plus an executed-cycle counter.
module crp16_debug_clock #(
  parameter int unsigned DIV_WIDTH       = 24,
  parameter int unsigned DB_WIDTH        = 20,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_WIDTH       = 16,
  parameter int unsigned BURST_WIDTH     = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic [4:0]             div_sel,
  input  logic                   step_key,
  input  logic [BURST_WIDTH-1:0] burst_len,
  input  logic                   clear_count,
  output logic                   cpu_en,
  output logic                   busy,
  output logic                   step_db,
  output logic [CNT_WIDTH-1:0]   cycle_count
);

  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  localparam int unsigned          SEL_MAX = DIV_WIDTH - 1;
  localparam logic [DB_WIDTH-1:0]  DB_LAST = DB_WIDTH'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_RUN   = 2'd1,
    S_BURST = 2'd2
  } state_t;

  state_t                 state;
  logic                   key_meta;
  logic                   key_sync;
  logic [DB_WIDTH-1:0]    db_cnt;
  logic                   step_db_q;
  logic                   press;
  logic [DIV_WIDTH-1:0]   div_cnt;
  logic [DIV_WIDTH-1:0]   div_mask;
  logic [4:0]             sel_eff;
  logic                   tick;
  logic [BURST_WIDTH-1:0] remaining;

  // Divider tap select, saturated to the widest usable period
  assign sel_eff  = (32'(div_sel) > SEL_MAX) ? 5'(SEL_MAX) : div_sel;
  assign div_mask = (DIV_WIDTH'(1) << sel_eff) - DIV_WIDTH'(1);
  assign tick     = ((div_cnt & div_mask) == div_mask);

  // Two-flop synchroniser for the asynchronous push button
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_meta <= 1'b0;
      key_sync <= 1'b0;
    end else begin
      key_meta <= step_key;
      key_sync <= key_meta;
    end
  end

  // Debouncer: accept the new level after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      db_cnt  <= '0;
      step_db <= 1'b0;
    end else if (key_sync == step_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt  <= '0;
      step_db <= ~step_db;
    end else begin
      db_cnt <= db_cnt + DB_WIDTH'(1);
    end
  end

  // Registered rising edge of the debounced key; release is ignored
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step_db_q <= 1'b0;
      press     <= 1'b0;
    end else begin
      step_db_q <= step_db;
      press     <= step_db & ~step_db_q;
    end
  end

  // Rate divider: free-running while active, parked at zero in HALT
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (state == S_HALT) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_WIDTH'(1);
    end
  end

  // Run-control state machine with registered cpu_en and busy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_HALT;
      cpu_en    <= 1'b0;
      busy      <= 1'b0;
      remaining <= '0;
    end else begin
      cpu_en <= 1'b0;
      case (state)
        S_HALT: begin
          if (mode == MODE_RUN) begin
            state <= S_RUN;
            busy  <= 1'b1;
          end else if (mode == MODE_STEP && press) begin
            cpu_en <= 1'b1;
          end else if (mode == MODE_BURST && press && burst_len != '0) begin
            remaining <= burst_len;
            state     <= S_BURST;
            busy      <= 1'b1;
          end
        end
        S_RUN: begin
          if (mode != MODE_RUN) begin
            state <= S_HALT;
            busy  <= 1'b0;
          end else if (tick) begin
            cpu_en <= 1'b1;
          end
        end
        S_BURST: begin
          if (mode != MODE_BURST) begin
            state     <= S_HALT;
            busy      <= 1'b0;
            remaining <= '0;
          end else if (tick) begin
            cpu_en    <= 1'b1;
            remaining <= remaining - BURST_WIDTH'(1);
            if (remaining == BURST_WIDTH'(1)) begin
              state <= S_HALT;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= S_HALT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Executed-cycle counter; clear wins over a coincident pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
    end else if (clear_count) begin
      cycle_count <= '0;
    end else if (cpu_en) begin
      cycle_count <= cycle_count + CNT_WIDTH'(1);
    end
  end

endmodule
